// File: rtl/drc_arb_pkg.sv
// Shared widths and request payload types for the DRC request arbiter.
package drc_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 272;
  localparam int SYN_W  = 32;
  localparam int ERR_W  = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } host_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SYN_W-1:0]  syndrome;
    logic [DATA_W-1:0] data;
    logic [ERR_W-1:0]  err;
  } ecc_req_t;

endpackage

// File: rtl/drc_req_arbiter_if.sv
// Host/ECC request inputs and DRC-facing issue outputs of the arbiter.
// DRC_ARB_STATS_EN adds the three grant/stall counter outputs.
interface drc_req_arbiter_if import drc_arb_pkg::*; #(
  parameter int ADDR_SIZE = ADDR_W
) ();
  logic                 host_valid_i;
  logic                 host_ready_o;
  logic                 host_we_i;
  logic [ADDR_SIZE-1:0] host_addr_i;
  logic [DATA_W-1:0]    host_data_i;
  logic                 ecc_valid_i;
  logic                 ecc_ready_o;
  logic [ADDR_SIZE-1:0] ecc_addr_i;
  logic [SYN_W-1:0]     ecc_syndrome_i;
  logic [DATA_W-1:0]    ecc_data_i;
  logic [ERR_W-1:0]     ecc_err_i;
  logic [ADDR_SIZE-1:0] addr_o;
  logic                 host_valid_o;
  logic                 host_we_o;
  logic [DATA_W-1:0]    host_data_o;
  logic                 ecc_valid_o;
  logic [SYN_W-1:0]     ecc_syndrome_o;
  logic [DATA_W-1:0]    ecc_data_o;
  logic [ERR_W-1:0]     ecc_err_o;
  logic                 hazard_stall_o;
`ifdef DRC_ARB_STATS_EN
  logic [31:0]          host_grant_cnt_o;
  logic [31:0]          ecc_grant_cnt_o;
  logic [31:0]          stall_cnt_o;
`endif

  modport slave (
    input  host_valid_i, host_we_i, host_addr_i, host_data_i,
    input  ecc_valid_i, ecc_addr_i, ecc_syndrome_i, ecc_data_i, ecc_err_i,
    output host_ready_o, ecc_ready_o,
    output addr_o, host_valid_o, host_we_o, host_data_o,
    output ecc_valid_o, ecc_syndrome_o, ecc_data_o, ecc_err_o,
    output hazard_stall_o
`ifdef DRC_ARB_STATS_EN
    , output host_grant_cnt_o, ecc_grant_cnt_o, stall_cnt_o
`endif
  );

  modport master (
    output host_valid_i, host_we_i, host_addr_i, host_data_i,
    output ecc_valid_i, ecc_addr_i, ecc_syndrome_i, ecc_data_i, ecc_err_i,
    input  host_ready_o, ecc_ready_o,
    input  addr_o, host_valid_o, host_we_o, host_data_o,
    input  ecc_valid_o, ecc_syndrome_o, ecc_data_o, ecc_err_o,
    input  hazard_stall_o
`ifdef DRC_ARB_STATS_EN
    , input host_grant_cnt_o, ecc_grant_cnt_o, stall_cnt_o
`endif
  );

endinterface

// File: rtl/drc_arb_fifo.sv
// Small synchronous FIFO, pointer based with a wrap bit to tell full from empty.
module drc_arb_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [PW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         wr_en, rd_en;

  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign dout_o  = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_en = push_i && !full_o;
    rd_en = pop_i && !empty_o;
    wr_d  = wr_q + (PW+1)'(wr_en);
    rd_d  = rd_q + (PW+1)'(rd_en);
  end

  // Storage is not reset; clearing the pointers is enough to flush.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[PW-1:0]] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/drc_req_arbiter.sv
// Buffers host requests and ECC reports, issues one per cycle to the DRC with
// ECC priority, bounded host starvation and a write-after-index hazard bubble.
// DRC_ARB_STATS_EN adds free-running host/ECC grant and stall counters.
module drc_req_arbiter import drc_arb_pkg::*; #(
  parameter int ADDR_SIZE  = ADDR_W,  // must not exceed ADDR_W
  parameter int IDX_SIZE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input logic             clk,
  input logic             rst,
  drc_req_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  host_req_t host_din, host_head;
  ecc_req_t  ecc_din, ecc_head;
  logic      host_full, host_empty, host_pop;
  logic      ecc_full, ecc_empty, ecc_pop;

  assign host_din = '{we: bus.host_we_i, addr: ADDR_W'(bus.host_addr_i), data: bus.host_data_i};
  assign ecc_din  = '{addr: ADDR_W'(bus.ecc_addr_i), syndrome: bus.ecc_syndrome_i,
                      data: bus.ecc_data_i, err: bus.ecc_err_i};

  drc_arb_fifo #(.T(host_req_t), .DEPTH(FIFO_DEPTH)) u_host_fifo (
    .clk(clk), .rst(rst), .push_i(bus.host_valid_i), .din_i(host_din),
    .pop_i(host_pop), .dout_o(host_head), .full_o(host_full), .empty_o(host_empty)
  );

  drc_arb_fifo #(.T(ecc_req_t), .DEPTH(FIFO_DEPTH)) u_ecc_fifo (
    .clk(clk), .rst(rst), .push_i(bus.ecc_valid_i), .din_i(ecc_din),
    .pop_i(ecc_pop), .dout_o(ecc_head), .full_o(ecc_full), .empty_o(ecc_empty)
  );

  assign bus.host_ready_o = !host_full;
  assign bus.ecc_ready_o  = !ecc_full;

  logic                 host_valid_q, host_valid_d;
  logic                 ecc_valid_q, ecc_valid_d;
  logic                 stall_q, stall_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    hdata_q, hdata_d;
  logic [SYN_W-1:0]     syn_q, syn_d;
  logic [DATA_W-1:0]    edata_q, edata_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 last_wr_q, last_wr_d;
  logic [IDX_SIZE-1:0]  last_idx_q, last_idx_d;

  logic                 pick_host, any_req, hazard;
  logic [ADDR_SIZE-1:0] host_addr, ecc_addr;
  logic [IDX_SIZE-1:0]  cand_idx;

  always_comb begin
    host_addr = ADDR_SIZE'(host_head.addr);
    ecc_addr  = ADDR_SIZE'(ecc_head.addr);
    any_req   = !host_empty || !ecc_empty;
    pick_host = !host_empty && (ecc_empty || starve_q == SW'(STARVE_MAX));
    cand_idx  = pick_host ? host_addr[IDX_SIZE-1:0] : ecc_addr[IDX_SIZE-1:0];
    hazard    = any_req && last_wr_q && (cand_idx == last_idx_q);

    host_valid_d = 1'b0;
    ecc_valid_d  = 1'b0;
    stall_d      = 1'b0;
    addr_d       = addr_q;
    we_d         = we_q;
    hdata_d      = hdata_q;
    syn_d        = syn_q;
    edata_d      = edata_q;
    err_d        = err_q;
    starve_d     = starve_q;
    last_wr_d    = 1'b0;
    last_idx_d   = last_idx_q;
    host_pop     = 1'b0;
    ecc_pop      = 1'b0;

    if (!any_req) begin
      starve_d = '0;
    end else if (hazard) begin
      // Bubble: nothing popped, starve count held, hazard record consumed.
      stall_d = 1'b1;
    end else if (pick_host) begin
      host_pop     = 1'b1;
      host_valid_d = 1'b1;
      addr_d       = host_addr;
      we_d         = host_head.we;
      hdata_d      = host_head.data;
      starve_d     = '0;
      last_wr_d    = host_head.we;
      last_idx_d   = host_addr[IDX_SIZE-1:0];
    end else begin
      ecc_pop     = 1'b1;
      ecc_valid_d = 1'b1;
      addr_d      = ecc_addr;
      syn_d       = ecc_head.syndrome;
      edata_d     = ecc_head.data;
      err_d       = ecc_head.err;
      last_wr_d   = 1'b1;
      last_idx_d  = ecc_addr[IDX_SIZE-1:0];
      if (host_empty)                         starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX))   starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_valid_q <= 1'b0;
      ecc_valid_q  <= 1'b0;
      stall_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      hdata_q      <= '0;
      syn_q        <= '0;
      edata_q      <= '0;
      err_q        <= '0;
      starve_q     <= '0;
      last_wr_q    <= 1'b0;
      last_idx_q   <= '0;
    end else begin
      host_valid_q <= host_valid_d;
      ecc_valid_q  <= ecc_valid_d;
      stall_q      <= stall_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      hdata_q      <= hdata_d;
      syn_q        <= syn_d;
      edata_q      <= edata_d;
      err_q        <= err_d;
      starve_q     <= starve_d;
      last_wr_q    <= last_wr_d;
      last_idx_q   <= last_idx_d;
    end
  end

  assign bus.addr_o         = addr_q;
  assign bus.host_valid_o   = host_valid_q;
  assign bus.host_we_o      = we_q;
  assign bus.host_data_o    = hdata_q;
  assign bus.ecc_valid_o    = ecc_valid_q;
  assign bus.ecc_syndrome_o = syn_q;
  assign bus.ecc_data_o     = edata_q;
  assign bus.ecc_err_o      = err_q;
  assign bus.hazard_stall_o = stall_q;

`ifdef DRC_ARB_STATS_EN
  logic [31:0] hcnt_q, hcnt_d, ecnt_q, ecnt_d, scnt_q, scnt_d;

  always_comb begin
    hcnt_d = hcnt_q + 32'(host_valid_d);
    ecnt_d = ecnt_q + 32'(ecc_valid_d);
    scnt_d = scnt_q + 32'(stall_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      ecnt_q <= '0;
      scnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      ecnt_q <= ecnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign bus.host_grant_cnt_o = hcnt_q;
  assign bus.ecc_grant_cnt_o  = ecnt_q;
  assign bus.stall_cnt_o      = scnt_q;
`endif

endmodule

// File: tb/tb_drc_req_arbiter.sv
// Scoreboard bench for drc_req_arbiter: a queue-based reference model predicts
// each cycle's issue, a separate monitor compares DUT outputs against it.
module tb_drc_req_arbiter;
  import drc_arb_pkg::*;

  localparam int AS = 24, DEPTH = 4, SMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drc_req_arbiter_if #(.ADDR_SIZE(AS)) bus ();

  drc_req_arbiter #(.ADDR_SIZE(AS), .IDX_SIZE(4), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic we; logic [AS-1:0] addr; logic [DATA_W-1:0] data;
  } mh_t;
  typedef struct {
    logic [AS-1:0] addr; logic [SYN_W-1:0] syn; logic [DATA_W-1:0] data; logic [ERR_W-1:0] err;
  } me_t;
  typedef struct {
    logic hv, ev, st, we;
    logic [AS-1:0] addr;
    logic [DATA_W-1:0] hdata;
    logic [SYN_W-1:0] syn;
    logic [DATA_W-1:0] edata;
    logic [ERR_W-1:0] err;
  } exp_t;

  mh_t  hq[$];
  me_t  eq[$];
  exp_t sb[$];
  exp_t cur;
  int   starve = 0;
  bit   lwr = 0;
  logic [3:0] lidx = '0;
  int   nhost = 0, necc = 0, nstall = 0;
  int   errs = 0, checks = 0;
  bit   run = 0;

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r = '0;
    for (int i = 0; i < 9; i++) r = {r[DATA_W-33:0], $urandom()};
    return r;
  endfunction

  function automatic logic [AS-1:0] rnd_addr(int max_idx);
    logic [31:0] t = $urandom();
    logic [3:0]  ix = 4'($urandom_range(0, max_idx));
    return {t[19:0], ix};
  endfunction

  // Reference: ECC first unless host waited SMAX ECC grants; a write/ECC
  // followed by a same-index candidate costs one idle cycle.
  task automatic model(bit r, mh_t h_in, bit hv, me_t e_in, bit ev);
    exp_t e;
    bit hacc, eacc, host_turn;
    logic [AS-1:0] a;
    mh_t h;
    me_t x;
    e = cur; e.hv = 0; e.ev = 0; e.st = 0;
    if (r) begin
      hq.delete(); eq.delete();
      starve = 0; lwr = 0; lidx = '0;
      nhost = 0; necc = 0; nstall = 0;
      e = '{default: '0};
    end else begin
      hacc = hv && (hq.size() < DEPTH);
      eacc = ev && (eq.size() < DEPTH);
      if (hq.size() == 0 && eq.size() == 0) begin
        lwr = 0; starve = 0;
      end else begin
        host_turn = (hq.size() > 0) && (eq.size() == 0 || starve == SMAX);
        a = host_turn ? hq[0].addr : eq[0].addr;
        if (lwr && a[3:0] == lidx) begin
          e.st = 1; lwr = 0; nstall++;
        end else if (host_turn) begin
          h = hq.pop_front();
          e.hv = 1; e.we = h.we; e.addr = h.addr; e.hdata = h.data;
          lwr = h.we; lidx = h.addr[3:0]; starve = 0; nhost++;
        end else begin
          x = eq.pop_front();
          e.ev = 1; e.addr = x.addr; e.syn = x.syn; e.edata = x.data; e.err = x.err;
          lwr = 1; lidx = x.addr[3:0]; necc++;
          starve = (hq.size() > 0) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        end
      end
      if (hacc) hq.push_back(h_in);
      if (eacc) eq.push_back(e_in);
    end
    cur = e;
    sb.push_back(e);
  endtask

  task automatic step(bit r, bit hv, bit we, logic [AS-1:0] ha, bit ev, logic [AS-1:0] ea);
    mh_t h; me_t x;
    @(negedge clk);
    if (run) begin
      chk("host_ready", bus.host_ready_o, hq.size() < DEPTH);
      chk("ecc_ready", bus.ecc_ready_o, eq.size() < DEPTH);
    end
    h = '{we: we, addr: ha, data: rnd_data()};
    x = '{addr: ea, syn: $urandom(), data: rnd_data(), err: 8'($urandom())};
    rst = r;
    bus.host_valid_i = hv; bus.host_we_i = h.we; bus.host_addr_i = h.addr; bus.host_data_i = h.data;
    bus.ecc_valid_i = ev; bus.ecc_addr_i = x.addr; bus.ecc_syndrome_i = x.syn;
    bus.ecc_data_i = x.data; bus.ecc_err_i = x.err;
    model(r, h, hv, x, ev);
    run = 1;
    @(posedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
  endtask

  // Monitor: one scoreboard entry per cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("excl_valid", bus.host_valid_o & bus.ecc_valid_o, 0);
          chk("ctl_hv_ev_st_we", {bus.host_valid_o, bus.ecc_valid_o, bus.hazard_stall_o, bus.host_we_o},
              {e.hv, e.ev, e.st, e.we});
          chk("addr", bus.addr_o, e.addr);
          chk("host_data", bus.host_data_o, e.hdata);
          chk("ecc_syn_err", {bus.ecc_syndrome_o, bus.ecc_err_o}, {e.syn, e.err});
          chk("ecc_data", bus.ecc_data_o, e.edata);
        end
      end
    end
  end

  initial begin
    bus.host_valid_i = 0; bus.host_we_i = 0; bus.host_addr_i = '0; bus.host_data_i = '0;
    bus.ecc_valid_i = 0; bus.ecc_addr_i = '0; bus.ecc_syndrome_i = '0;
    bus.ecc_data_i = '0; bus.ecc_err_i = '0;

    step(1, 0, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0);
    idle(1);

    // single host read
    step(0, 1, 0, 24'h000123, 0, '0);
    idle(3);
    // ECC and host together
    step(0, 1, 0, 24'h000022, 1, 24'h000011);
    idle(3);
    // write then same-index read
    step(0, 1, 1, 24'h0000A5, 0, '0);
    step(0, 1, 0, 24'h0001F5, 0, '0);
    idle(4);
    // ECC stream with one pending host read
    step(0, 1, 0, 24'h000008, 1, 24'h000101);
    for (int i = 2; i < 9; i++) step(0, 0, 0, '0, 1, AS'(24'h000100 + i));
    idle(4);
    // ECC traffic while the host FIFO fills with writes
    for (int i = 0; i < 8; i++) step(0, 1, 1, AS'(24'h000300 + 8 + (i % 4)), 1, AS'(24'h000200 + (i % 7) + 1));
    idle(14);
    // reset with entries queued
    step(0, 1, 1, 24'h000041, 1, 24'h000051);
    step(0, 1, 1, 24'h000042, 1, 24'h000052);
    step(1, 1, 1, 24'h000043, 1, 24'h000053);
    idle(4);

    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 5), 1'($urandom()), rnd_addr(3),
           ($urandom_range(0, 9) < 4), rnd_addr(3));
    idle(20);

    #2;
    run = 0;
    chk("scoreboard_drained", sb.size(), 0);
`ifdef DRC_ARB_STATS_EN
    chk("host_grant_cnt", bus.host_grant_cnt_o, nhost);
    chk("ecc_grant_cnt", bus.ecc_grant_cnt_o, necc);
    chk("stall_cnt", bus.stall_cnt_o, nstall);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
